// File: rtl/hazard_pkg.sv
// Shared FPU class encodings, timer states and latency lookup for the hazard/stall unit.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package hazard_pkg;

    typedef enum logic [1:0] {
        FPC_NONE = 2'b00,
        FPC_ADD  = 2'b01,
        FPC_DIV  = 2'b10,
        FPC_RSVD = 2'b11
    } fpc_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } tmr_state_e;

    // Reserved class behaves like a single-cycle op.
    function automatic int unsigned fpc_latency(logic [1:0] cls,
                                                int unsigned add_lat,
                                                int unsigned div_lat);
        case (cls)
            FPC_ADD: return add_lat;
            FPC_DIV: return div_lat;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID/EX hazard inputs and pipeline stall/flush controls bundled as one port.
// Latency: n/a (wires only).
// Backpressure: n/a; the slave side produces the stall controls.
interface hazard_stall_unit_if;
    logic [4:0]  ID_Rs1;
    logic [4:0]  ID_Rs2;
    logic [4:0]  ID_frs3;
    logic        ID_rs1_used;
    logic        ID_rs2_used;
    logic        ID_rs3_used;
    logic        ID_rs1_f;
    logic        ID_rs2_f;
    logic [4:0]  EX_Rd;
    logic        EX_MemRead;
    logic        EX_RegWrite;
    logic        EX_f_RegWrite;
    logic [1:0]  EX_fpu_class;
    logic        EX_branch_taken;
    logic        stall_if;
    logic        flush_if;
    logic        bubble_ex;
    logic        hold_ex;
    logic        bubble_mem;
    logic        fpu_start;
    logic        fpu_done;
    logic [31:0] stall_cycles;

    modport master (
        output ID_Rs1, ID_Rs2, ID_frs3, ID_rs1_used, ID_rs2_used, ID_rs3_used,
               ID_rs1_f, ID_rs2_f, EX_Rd, EX_MemRead, EX_RegWrite, EX_f_RegWrite,
               EX_fpu_class, EX_branch_taken,
        input  stall_if, flush_if, bubble_ex, hold_ex, bubble_mem,
               fpu_start, fpu_done, stall_cycles
    );

    modport slave (
        input  ID_Rs1, ID_Rs2, ID_frs3, ID_rs1_used, ID_rs2_used, ID_rs3_used,
               ID_rs1_f, ID_rs2_f, EX_Rd, EX_MemRead, EX_RegWrite, EX_f_RegWrite,
               EX_fpu_class, EX_branch_taken,
        output stall_if, flush_if, bubble_ex, hold_ex, bubble_mem,
               fpu_start, fpu_done, stall_cycles
    );
endinterface

// File: rtl/hazard_fpu_timer.sv
// EX-occupancy timer for multi-cycle FP ops: start/done pulses and EX hold.
// Latency: op of latency L holds for L-1 cycles, done in cycle L.
// Backpressure: none; while busy the incoming class is ignored.
module hazard_fpu_timer
    import hazard_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] lat,
    output logic             start,
    output logic             done,
    output logic             hold
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    tmr_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start     = 1'b0;
        done      = 1'b0;
        hold      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (lat > ONE) begin
                    start     = 1'b1;
                    hold      = 1'b1;
                    cnt_nxt   = lat - ONE;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt > ONE) begin
                    hold    = 1'b1;
                    cnt_nxt = cnt - ONE;
                end else begin
                    // Result leaves EX at this edge.
                    done      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline stall/flush control: load-use bubbles, multi-cycle FPU holds, branch flush.
// Latency: controls are combinational from ID/EX state; stall counter updates next edge.
// Backpressure: stall_if/hold_ex freeze upstream stages; branch flush overrides load-use.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int FADD_LAT = 3,
    parameter int FDIV_LAT = 10,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    hazard_stall_unit_if.slave hz
);

    logic [CNT_W-1:0] lat;
    logic             tmr_start, tmr_done, tmr_hold;
    logic             int_hit, flt_hit, load_use, flush, stall_raw;
    logic [31:0]      stall_cnt;

    always_comb begin
        lat = CNT_W'(fpc_latency(hz.EX_fpu_class, FADD_LAT, FDIV_LAT));
    end

    hazard_fpu_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .lat   (lat),
        .start (tmr_start),
        .done  (tmr_done),
        .hold  (tmr_hold)
    );

    always_comb begin
        int_hit = (hz.ID_rs1_used && !hz.ID_rs1_f && (hz.ID_Rs1 == hz.EX_Rd)) ||
                  (hz.ID_rs2_used && !hz.ID_rs2_f && (hz.ID_Rs2 == hz.EX_Rd));
        // f0 is a real register, so float matches do not exclude Rd==0.
        flt_hit = (hz.ID_rs1_used &&  hz.ID_rs1_f && (hz.ID_Rs1  == hz.EX_Rd)) ||
                  (hz.ID_rs2_used &&  hz.ID_rs2_f && (hz.ID_Rs2  == hz.EX_Rd)) ||
                  (hz.ID_rs3_used &&                 (hz.ID_frs3 == hz.EX_Rd));
        load_use  = hz.EX_MemRead &&
                    ((hz.EX_RegWrite && (hz.EX_Rd != 5'd0) && int_hit) ||
                     (hz.EX_f_RegWrite && flt_hit));
        // A branch cannot coexist with an FP op in EX; it is ignored while holding.
        flush     = hz.EX_branch_taken && !tmr_hold;
        stall_raw = tmr_hold || (load_use && !flush);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_raw && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    always_comb begin
        hz.stall_if     = !reset && stall_raw;
        hz.flush_if     = !reset && flush;
        hz.bubble_ex    = !reset && (flush || load_use);
        hz.hold_ex      = !reset && tmr_hold;
        hz.bubble_mem   = !reset && tmr_hold;
        hz.fpu_start    = !reset && tmr_start;
        hz.fpu_done     = !reset && tmr_done;
        hz.stall_cycles = reset ? 32'd0 : stall_cnt;
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed plus random checks of hazard_stall_unit against an instruction-level reference model.
module tb_hazard_stall_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_stall_unit_if hz ();

    hazard_stall_unit #(.FADD_LAT(3), .FDIV_LAT(10), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: current FP op latency (0 = none), cycles already spent, stall total.
    int          m_lat  = 0;
    int          m_done = 0;
    logic [31:0] m_cnt  = 32'd0;

    // Last sampled DUT outputs, for directed checks against fixed values.
    logic        s_stall, s_flush, s_bub, s_hold, s_bmem, s_start, s_done;
    logic [31:0] s_cyc;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_lat(logic [1:0] c);
        if (c == 2'b01) return 3;
        if (c == 2'b10) return 10;
        return 1;
    endfunction

    function automatic bit ref_load_use();
        bit         used[3];
        bit         isf[3];
        logic [4:0] rg[3];
        bit         hit_i = 0;
        bit         hit_f = 0;
        used = '{hz.ID_rs1_used, hz.ID_rs2_used, hz.ID_rs3_used};
        isf  = '{hz.ID_rs1_f, hz.ID_rs2_f, 1'b1};
        rg   = '{hz.ID_Rs1, hz.ID_Rs2, hz.ID_frs3};
        for (int i = 0; i < 3; i++) begin
            if (used[i] && rg[i] == hz.EX_Rd) begin
                if (isf[i]) hit_f = 1;
                else        hit_i = 1;
            end
        end
        return hz.EX_MemRead && ((hz.EX_RegWrite && hz.EX_Rd != 0 && hit_i) ||
                                 (hz.EX_f_RegWrite && hit_f));
    endfunction

    task automatic clear_inputs();
        hz.ID_Rs1 = 0; hz.ID_Rs2 = 0; hz.ID_frs3 = 0;
        hz.ID_rs1_used = 0; hz.ID_rs2_used = 0; hz.ID_rs3_used = 0;
        hz.ID_rs1_f = 0; hz.ID_rs2_f = 0;
        hz.EX_Rd = 0; hz.EX_MemRead = 0; hz.EX_RegWrite = 0; hz.EX_f_RegWrite = 0;
        hz.EX_fpu_class = 2'b00; hz.EX_branch_taken = 0;
    endtask

    task automatic rand_id();
        hz.ID_Rs1      = 5'($urandom_range(0, 3));
        hz.ID_Rs2      = 5'($urandom_range(0, 3));
        hz.ID_frs3     = 5'($urandom_range(0, 3));
        hz.ID_rs1_used = 1'($urandom_range(0, 1));
        hz.ID_rs2_used = 1'($urandom_range(0, 1));
        hz.ID_rs3_used = 1'($urandom_range(0, 1));
        hz.ID_rs1_f    = 1'($urandom_range(0, 1));
        hz.ID_rs2_f    = 1'($urandom_range(0, 1));
    endtask

    // One pipeline cycle: sample at the falling edge, compare with the model, advance.
    task automatic tick();
        bit act, lu, e_start, e_done, e_hold, e_flush, e_stall, e_bub;
        int c_lat, c_idx;
        #4;
        act = 0; c_lat = 1; c_idx = 1;
        if (m_lat != 0) begin
            act = 1; c_lat = m_lat; c_idx = m_done + 1;
        end else if (ref_lat(hz.EX_fpu_class) > 1) begin
            act = 1; c_lat = ref_lat(hz.EX_fpu_class); c_idx = 1;
        end
        e_start = act && c_idx == 1;
        e_done  = act && c_idx == c_lat;
        e_hold  = act && c_idx < c_lat;
        lu      = ref_load_use();
        e_flush = hz.EX_branch_taken && !e_hold;
        e_stall = e_hold || (lu && !e_flush);
        e_bub   = e_flush || lu;
        if (reset) begin
            {e_start, e_done, e_hold, e_flush, e_stall, e_bub} = '0;
        end else if (act) begin
            check("no_branch_during_fp_op", {31'd0, hz.EX_branch_taken}, 32'd0);
        end
        s_stall = hz.stall_if;  s_flush = hz.flush_if;  s_bub = hz.bubble_ex;
        s_hold  = hz.hold_ex;   s_bmem  = hz.bubble_mem;
        s_start = hz.fpu_start; s_done  = hz.fpu_done;  s_cyc = hz.stall_cycles;
        check("stall_if",     {31'd0, s_stall}, {31'd0, e_stall});
        check("flush_if",     {31'd0, s_flush}, {31'd0, e_flush});
        check("bubble_ex",    {31'd0, s_bub},   {31'd0, e_bub});
        check("hold_ex",      {31'd0, s_hold},  {31'd0, e_hold});
        check("bubble_mem",   {31'd0, s_bmem},  {31'd0, e_hold});
        check("fpu_start",    {31'd0, s_start}, {31'd0, e_start});
        check("fpu_done",     {31'd0, s_done},  {31'd0, e_done});
        check("stall_cycles", s_cyc, reset ? 32'd0 : m_cnt);
        @(posedge clk);
        if (reset) begin
            m_lat = 0; m_done = 0; m_cnt = 0;
        end else begin
            if (act && c_idx < c_lat) begin
                m_lat = c_lat; m_done = c_idx;
            end else begin
                m_lat = 0; m_done = 0;
            end
            if (e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        clear_inputs();
        // Reset with a live load-use pattern: every output must stay 0.
        reset = 1;
        hz.EX_MemRead = 1; hz.EX_RegWrite = 1; hz.EX_Rd = 5;
        hz.ID_Rs1 = 5; hz.ID_rs1_used = 1; hz.EX_branch_taken = 1;
        tick();
        check("reset_stall", {31'd0, s_stall}, 32'd0);
        check("reset_bub",   {31'd0, s_bub},   32'd0);
        check("reset_flush", {31'd0, s_flush}, 32'd0);
        clear_inputs();
        tick();
        reset = 0;

        // lw x5 ; add x6,x5,x1
        hz.EX_MemRead = 1; hz.EX_RegWrite = 1; hz.EX_Rd = 5;
        hz.ID_Rs1 = 5; hz.ID_rs1_used = 1; hz.ID_Rs2 = 1; hz.ID_rs2_used = 1;
        tick();
        check("lu_int_stall",  {31'd0, s_stall}, 32'd1);
        check("lu_int_bubble", {31'd0, s_bub},   32'd1);
        clear_inputs();
        hz.ID_Rs1 = 5; hz.ID_rs1_used = 1;
        tick();
        check("lu_int_one_bubble", {31'd0, s_stall}, 32'd0);
        // Same shape with Rd = x0
        hz.EX_MemRead = 1; hz.EX_RegWrite = 1; hz.EX_Rd = 0;
        hz.ID_Rs1 = 0; hz.ID_rs1_used = 1;
        tick();
        check("lu_x0_no_stall", {31'd0, s_stall}, 32'd0);

        // flw f3 ; fmadd with frs3 = f3
        clear_inputs();
        hz.EX_MemRead = 1; hz.EX_f_RegWrite = 1; hz.EX_Rd = 3;
        hz.ID_frs3 = 3; hz.ID_rs3_used = 1;
        tick();
        check("lu_flt_rs3_stall", {31'd0, s_stall}, 32'd1);
        hz.ID_rs3_used = 0; hz.ID_Rs1 = 3; hz.ID_rs1_used = 1; hz.ID_rs1_f = 0;
        tick();
        check("lu_file_mismatch", {31'd0, s_stall}, 32'd0);

        // fdiv occupying EX for 10 cycles
        clear_inputs();
        hz.EX_fpu_class = 2'b10;
        for (int c = 1; c <= 10; c++) begin
            tick();
            check("div_start", {31'd0, s_start}, (c == 1)  ? 32'd1 : 32'd0);
            check("div_hold",  {31'd0, s_hold},  (c < 10)  ? 32'd1 : 32'd0);
            check("div_done",  {31'd0, s_done},  (c == 10) ? 32'd1 : 32'd0);
        end
        hz.EX_fpu_class = 2'b00;
        tick();
        check("div_idle_after", {31'd0, s_hold | s_start | s_done}, 32'd0);

        // Two back-to-back add-class ops from a clean counter
        do_reset();
        hz.EX_fpu_class = 2'b01;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check("add2_start", {31'd0, s_start}, (c % 3 == 1) ? 32'd1 : 32'd0);
            check("add2_hold",  {31'd0, s_hold},  (c % 3 != 0) ? 32'd1 : 32'd0);
            check("add2_done",  {31'd0, s_done},  (c % 3 == 0) ? 32'd1 : 32'd0);
        end
        hz.EX_fpu_class = 2'b00;
        tick();
        check("add2_stall_cycles", s_cyc, 32'd4);

        // Load-use and taken branch together
        hz.EX_MemRead = 1; hz.EX_RegWrite = 1; hz.EX_Rd = 7;
        hz.ID_Rs2 = 7; hz.ID_rs2_used = 1; hz.EX_branch_taken = 1;
        tick();
        check("br_lu_flush",  {31'd0, s_flush}, 32'd1);
        check("br_lu_bubble", {31'd0, s_bub},   32'd1);
        check("br_lu_stall",  {31'd0, s_stall}, 32'd0);

        // Reset during cycle 4 of an fdiv
        clear_inputs();
        hz.EX_fpu_class = 2'b10;
        for (int c = 1; c <= 3; c++) tick();
        reset = 1;
        tick();
        check("rst_mid_hold", {31'd0, s_hold}, 32'd0);
        reset = 0;
        hz.EX_fpu_class = 2'b00;
        tick();
        check("rst_mid_no_done", {31'd0, s_done}, 32'd0);
        check("rst_mid_no_hold", {31'd0, s_hold}, 32'd0);
        check("rst_mid_cycles",  s_cyc,           32'd0);

        // Random instruction stream
        for (int n = 0; n < 400; n++) begin
            int kind;
            clear_inputs();
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                hz.EX_MemRead = 1;
                if ($urandom_range(0, 1) == 1) hz.EX_RegWrite = 1;
                else                           hz.EX_f_RegWrite = 1;
                hz.EX_Rd = 5'($urandom_range(0, 3));
                hz.EX_branch_taken = ($urandom_range(0, 3) == 0);
                rand_id();
                tick();
            end else if (kind == 1) begin
                int lat;
                hz.EX_fpu_class = 2'($urandom_range(0, 3));
                hz.EX_f_RegWrite = 1;
                hz.EX_Rd = 5'($urandom_range(0, 3));
                lat = ref_lat(hz.EX_fpu_class);
                for (int c = 0; c < lat; c++) begin
                    rand_id();
                    tick();
                end
            end else begin
                hz.EX_RegWrite = 1'($urandom_range(0, 1));
                hz.EX_Rd = 5'($urandom_range(0, 3));
                hz.EX_branch_taken = 1'($urandom_range(0, 1));
                rand_id();
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Stall/flush controller for the 5-stage RISC-V integer+FPU pipeline. It covers the hazards that the MEM/WB bypass path cannot resolve: integer and float load-use, multi-cycle FPU ops occupying EX, and taken-branch redirect. It sits beside the ID and EX stages, drives the pipeline-register write-enable and bubble controls, and owns the EX-occupancy counter for multi-cycle FP operations.

## Interface
Parameters:
- FADD_LAT, 3, total EX cycles for fadd/fsub/fmul class (>=1)
- FDIV_LAT, 10, total EX cycles for fdiv/fsqrt class (>=1)
- CNT_W, 4, counter width; must hold max(FADD_LAT,FDIV_LAT)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock
- reset  in  1  synchronous active-high reset
- ID_Rs1, ID_Rs2, ID_frs3  in  5 each  source register fields of the instruction in ID
- ID_rs1_used, ID_rs2_used, ID_rs3_used  in  1 each  source actually read
- ID_rs1_f, ID_rs2_f  in  1 each  source is in the float file (rs3 is always float)
- EX_Rd  in  5  destination of the instruction in EX
- EX_MemRead, EX_RegWrite, EX_f_RegWrite  in  1 each  EX-stage controls
- EX_fpu_class  in  2  00 single-cycle/none, 01 add class, 10 div class, 11 reserved (treated as 00)
- EX_branch_taken  in  1  branch/jump in EX redirects PC this cycle
- stall_if  out  1  hold PC and IF/ID
- flush_if  out  1  zero IF/ID
- bubble_ex  out  1  load NOP control into ID/EX
- hold_ex  out  1  freeze ID/EX
- bubble_mem  out  1  load NOP control into EX/MEM
- fpu_start, fpu_done  out  1 each  single-cycle pulses
- stall_cycles  out  32  saturating count of cycles with stall_if=1

## Operation
- States: IDLE (cnt=0), BUSY (cnt>0).
- IDLE with EX_fpu_class decoding to latency L>1: fpu_start=1, hold_ex=1, bubble_mem=1, stall_if=1, cnt<=L-1, go BUSY. L=1 classes never leave IDLE.
- BUSY, cnt>1: hold_ex=bubble_mem=stall_if=1, cnt<=cnt-1.
- BUSY, cnt==1: all holds 0, fpu_done=1, cnt<=0, go IDLE; result advances to EX/MEM at that edge.
- Load-use (comb, any state): EX_MemRead & ((EX_RegWrite & EX_Rd!=0 & match on an integer source) | (EX_f_RegWrite & match on a float source, f0 included)). A source matches when its used flag is set, its file equals the writer's file, and its field equals EX_Rd. Response: stall_if=1, bubble_ex=1.
- EX_branch_taken: flush_if=1, bubble_ex=1, stall_if forced 0 so the redirect takes effect. It overrides load-use.
- EX_branch_taken while BUSY is illegal: the EX op is an FP op. The unit ignores it and the bench asserts it never happens.
- stall_cycles increments each cycle stall_if=1 and saturates at 0xFFFF_FFFF.

## Timing
- Reset: cnt=0, state IDLE, stall_cycles=0. While reset is high, every output is forced 0.
- Reset mid-BUSY: the next cycle is IDLE with no fpu_done pulse.
- An op of latency L occupies EX for exactly L cycles. hold_ex is high for the first L-1 of them. fpu_start is in cycle 1 and fpu_done in cycle L.
- Back-to-back FP ops: the second enters EX in the cycle after fpu_done and starts in IDLE with no gap cycle.
- Load-use costs exactly 1 bubble. After the bubble, WB→EX forwarding supplies the value.
- A load in EX is never simultaneous with BUSY, so load-use and FP hold do not overlap.

## Structure
- Shared package (hazard_pkg): fpu_class encodings (FPC_NONE, FPC_ADD, FPC_DIV) and a latency-lookup function.
- One sub-module, hazard_fpu_timer: counter, IDLE/BUSY state, start/done pulses, and hold generation.
- Load-use compare, flush priority, and the stall counter stay in the top level.

## Test plan
- lw x5 in EX, ID add x6,x5,x1 (rs1_used) -> stall_if=1 and bubble_ex=1 for one cycle. The same case with EX_Rd=0 -> no stall.
- flw f3 in EX, ID fmadd with frs3=3 -> one-cycle stall. Integer ID reading x3 -> no stall (file mismatch).
- EX_fpu_class=10, FDIV_LAT=10 -> fpu_start at cycle 1, hold_ex high for cycles 1-9, fpu_done at cycle 10, then IDLE.
- Two consecutive add-class ops -> holds of 2+2 cycles with fpu_done and the next fpu_start in adjacent cycles, and stall_cycles=4.
- Load-use together with EX_branch_taken -> flush_if=1, bubble_ex=1, stall_if=0.
- reset pulsed during cycle 4 of an FDIV -> next cycle all outputs 0, no fpu_done, and stall_cycles=0.
